// File: rtl/router_pkg.sv
// Shared router definitions: header field layout, default widths and field helpers.
// Used by the packet FIFO, the router FSM and the register block.
package router_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int HDR_LEN_LSB    = 2;
    localparam int HDR_DEST_W     = 2;

    // Fill-level width: one extra bit so a completely full FIFO is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Payload length field of a header word, zero-extended.
    function automatic logic [31:0] hdr_len(input logic [31:0] word);
        return word >> HDR_LEN_LSB;
    endfunction

    function automatic logic [HDR_DEST_W-1:0] hdr_dest(input logic [31:0] word);
        return word[HDR_DEST_W-1:0];
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array with one synchronous write port and one combinational read port.
// No reset: contents are only meaningful between the FIFO pointers.
module router_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output-channel FIFO; write visible to read one edge later, data_out registered one cycle.
// No backpressure: writes when full are dropped (overflow pulse), reads when empty are ignored (underflow pulse).
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = DEPTH - 2
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       soft_reset,
    input  logic                       write_enb,
    input  logic                       lfd_state,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       read_enb,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [lvl_w(DEPTH)-1:0]    level,
    output logic [DATA_WIDTH-2:0]      pkt_remaining,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = lvl_w(DEPTH);
    localparam int CW = DATA_WIDTH - 1;
    localparam logic [PW-1:0] AFULL_L = PW'(AFULL_LVL);

    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic [CW-1:0]         pkt_q, pkt_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic [DATA_WIDTH:0]   rd_word;
    logic                  wr_acc, rd_acc;

    assign empty       = (wp_q == rp_q);
    assign full        = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign level       = wp_q - rp_q;
    assign almost_full = (level >= AFULL_L);

    assign wr_acc = write_enb && !full && !soft_reset;
    assign rd_acc = read_enb && !empty && !soft_reset;

    router_fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_acc),
        .wr_addr (wp_q[AW-1:0]),
        .wr_data ({lfd_state, data_in}),
        .rd_addr (rp_q[AW-1:0]),
        .rd_data (rd_word)
    );

    always_comb begin
        wp_d         = wp_q;
        rp_d         = rp_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        pkt_d        = pkt_q;
        ovf_d        = 1'b0;
        unf_d        = 1'b0;
        if (soft_reset) begin
            wp_d         = '0;
            rp_d         = '0;
            data_out_d   = '0;
            data_valid_d = 1'b0;
            pkt_d        = '0;
        end else begin
            ovf_d = write_enb && full;
            unf_d = read_enb && empty;
            if (wr_acc) begin
                wp_d = wp_q + PW'(1);
            end
            if (rd_acc) begin
                rp_d         = rp_q + PW'(1);
                data_out_d   = rd_word[DATA_WIDTH-1:0];
                data_valid_d = 1'b1;
                if (rd_word[DATA_WIDTH]) begin
                    // Payload words plus the trailing parity word.
                    pkt_d = CW'(hdr_len(32'(rd_word[DATA_WIDTH-1:0]))) + CW'(1);
                end else if (pkt_q != '0) begin
                    pkt_d = pkt_q - CW'(1);
                end
            end else if (!read_enb && pkt_q == '0) begin
                // An underflowing read leaves data_out untouched; only a true idle clears it.
                data_out_d   = '0;
                data_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wp_q         <= '0;
            rp_q         <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            pkt_q        <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            pkt_q        <= pkt_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    assign data_out      = data_out_q;
    assign data_valid    = data_valid_q;
    assign pkt_remaining = pkt_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo (DATA_WIDTH=8, DEPTH=16) with hand-computed expectations.
module tb_router_pkt_fifo;

    logic       clock = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       data_valid;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] level;
    logic [6:0] pkt_remaining;
    logic       overflow;
    logic       underflow;

    int n_chk = 0;
    int n_bad = 0;
    logic [7:0] q[$];

    router_pkt_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_LVL(14)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .soft_reset    (soft_reset),
        .write_enb     (write_enb),
        .lfd_state     (lfd_state),
        .data_in       (data_in),
        .read_enb      (read_enb),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .empty         (empty),
        .full          (full),
        .almost_full   (almost_full),
        .level         (level),
        .pkt_remaining (pkt_remaining),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        soft_reset = 1'b0;
        data_in    = 8'h00;
    endtask

    task automatic wr(input logic [7:0] d, input logic tag);
        write_enb = 1'b1;
        lfd_state = tag;
        data_in   = d;
        read_enb  = 1'b0;
        tick();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        idle_in();
        tick();
        tick();
        chk("rst_dout", data_out, 0);
        chk("rst_vld", data_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_level", level, 0);
        chk("rst_pkt", pkt_remaining, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        resetn = 1'b1;
        tick();

        // Header 0D (len 3) then two payload words.
        wr(8'h0D, 1'b1);
        chk("wr1_empty", empty, 0);
        chk("wr1_level", level, 1);
        wr(8'hA1, 1'b0);
        wr(8'hA2, 1'b0);
        chk("wr3_level", level, 3);
        read_enb = 1'b1;
        tick();
        chk("rd_hdr", data_out, 8'h0D);
        chk("rd_hdr_vld", data_valid, 1);
        chk("rd_hdr_pkt", pkt_remaining, 4);
        tick();
        chk("rd_a1", data_out, 8'hA1);
        chk("rd_a1_pkt", pkt_remaining, 3);
        tick();
        chk("rd_a2", data_out, 8'hA2);
        chk("rd_a2_pkt", pkt_remaining, 2);
        chk("rd_a2_empty", empty, 1);
        read_enb = 1'b0;
        wr(8'hB1, 1'b0);
        chk("hold_dout", data_out, 8'hA2);
        chk("hold_vld", data_valid, 1);
        wr(8'hB2, 1'b0);
        read_enb = 1'b1;
        tick();
        chk("rd_b1", data_out, 8'hB1);
        chk("rd_b1_pkt", pkt_remaining, 1);
        tick();
        chk("rd_b2", data_out, 8'hB2);
        chk("rd_b2_pkt", pkt_remaining, 0);
        read_enb = 1'b0;
        tick();
        chk("idle_dout", data_out, 0);
        chk("idle_vld", data_valid, 0);

        // Underflow: read from empty.
        read_enb = 1'b1;
        tick();
        chk("unf_pulse", underflow, 1);
        chk("unf_dout", data_out, 0);
        chk("unf_level", level, 0);
        read_enb = 1'b0;
        wr(8'hC5, 1'b0);
        chk("unf_clear", underflow, 0);
        read_enb = 1'b1;
        tick();
        chk("unf_rp_data", data_out, 8'hC5);
        chk("unf_rp_pkt", pkt_remaining, 0);
        read_enb = 1'b0;
        tick();
        chk("idle2_dout", data_out, 0);

        // Fill 16, then overflow.
        for (int i = 0; i < 16; i++) begin
            wr(8'h40 + 8'(i), 1'b0);
            if (i == 12) chk("afull_13", almost_full, 0);
            if (i == 13) chk("afull_14", almost_full, 1);
            if (i == 14) chk("full_15", full, 0);
        end
        chk("full16", full, 1);
        chk("level16", level, 16);
        wr(8'hFF, 1'b0);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_level", level, 16);
        tick();
        chk("ovf_clear", overflow, 0);

        // Drain to level 5, then 40 cycles of simultaneous read/write.
        read_enb = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("drain", data_out, 8'h40 + 8'(i));
        end
        read_enb = 1'b0;
        chk("drain_level", level, 5);
        for (int i = 11; i < 16; i++) q.push_back(8'h40 + 8'(i));
        for (int k = 0; k < 40; k++) begin
            logic [7:0] exp;
            write_enb = 1'b1;
            data_in   = 8'h60 + 8'(k);
            read_enb  = 1'b1;
            tick();
            exp = q.pop_front();
            q.push_back(8'h60 + 8'(k));
            chk("rw_data", data_out, exp);
            chk("rw_level", level, 5);
        end
        idle_in();
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        chk("sr1_empty", empty, 1);

        // Soft reset at level 9 with a packet mid-read, competing with read and write.
        wr(8'h11, 1'b1);
        for (int i = 0; i < 10; i++) wr(8'hD0 + 8'(i), 1'b0);
        read_enb = 1'b1;
        tick();
        chk("sr_hdr_pkt", pkt_remaining, 5);
        tick();
        chk("sr_d0", data_out, 8'hD0);
        chk("sr_pkt4", pkt_remaining, 4);
        chk("sr_level9", level, 9);
        soft_reset = 1'b1;
        write_enb  = 1'b1;
        data_in    = 8'h77;
        tick();
        idle_in();
        chk("sr_empty", empty, 1);
        chk("sr_level", level, 0);
        chk("sr_vld", data_valid, 0);
        chk("sr_pkt", pkt_remaining, 0);
        chk("sr_dout", data_out, 0);
        chk("sr_ovf", overflow, 0);
        chk("sr_unf", underflow, 0);
        wr(8'h0C, 1'b1);
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        chk("sr_new_data", data_out, 8'h0C);
        chk("sr_new_pkt", pkt_remaining, 4);

        // Asynchronous reset mid-burst.
        wr(8'h09, 1'b1);
        wr(8'h31, 1'b0);
        wr(8'h32, 1'b0);
        read_enb = 1'b1;
        tick();
        tick();
        chk("ar_pre_pkt", pkt_remaining, 2);
        read_enb = 1'b0;
        #3;
        resetn = 1'b0;
        #1;
        chk("ar_dout", data_out, 0);
        chk("ar_vld", data_valid, 0);
        chk("ar_empty", empty, 1);
        chk("ar_level", level, 0);
        chk("ar_pkt", pkt_remaining, 0);
        tick();
        resetn = 1'b1;
        tick();
        chk("ar_after_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
